// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: funct3 codes, FSM encoding,
// exception causes and the access-size / alignment helpers.
package mau_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQ       = 2'b01,
    ST_WAIT_RESP = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_LD_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_ST_MISAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  // Unsigned variants share the size of their signed twins; undefined codes act as word.
  function automatic size_t access_size(input logic [2:0] f3);
    case ({1'b0, f3[1:0]})
      F3_SB:   return SZ_B;
      F3_SH:   return SZ_H;
      F3_SW:   return SZ_W;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load result extraction: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to funct3.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h000000, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0000, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mau_lsu.sv
// Memory access unit: captures a load/store from execute, runs the
// request/grant/response bus handshake and returns aligned load data.
module mau_lsu
  import mau_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255,
  parameter int RD_W         = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            riscv_LOAD,
  input  logic            riscv_STORE,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr_toMAU,
  input  logic [31:0]     data_toMAU,
  input  logic [RD_W-1:0] rd_idx,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            ld_we,
  output logic [RD_W-1:0] ld_rd,
  output logic [31:0]     ld_data,
  output logic            MAU_data_conflict,
  output logic            mau_exc,
  output logic [1:0]      mau_exc_cause
);

  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_we_q, ld_we_d;
  logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              exc_q, exc_d;
  logic [1:0]        cause_q, cause_d;

  logic        req_any, misal, misal_hit, accept, resp_hit, timeout;
  size_t       sz;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ld_ext;

  mau_load_align u_load_align (
    .rdata_i  (mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_ext)
  );

  always_comb begin
    req_any   = riscv_LOAD | riscv_STORE;
    sz        = access_size(funct3);
    misal     = misaligned(sz, addr_toMAU[1:0]);
    misal_hit = (state_q == ST_IDLE) && req_any && misal;
    accept    = (state_q == ST_IDLE) && req_any && !misal;
    resp_hit  = (state_q == ST_WAIT_RESP) && mem_rvalid;
    timeout   = (state_q == ST_WAIT_RESP) && !mem_rvalid && (cnt_q == CNT_LAST);
    // Stores replicate the datum across all lanes; byte enables pick the live one.
    case (sz)
      SZ_B: begin
        be_new    = 4'b0001 << addr_toMAU[1:0];
        wdata_new = {4{data_toMAU[7:0]}};
      end
      SZ_H: begin
        be_new    = 4'b0011 << addr_toMAU[1:0];
        wdata_new = {2{data_toMAU[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = data_toMAU;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_REQ;
      ST_REQ:       if (mem_gnt) state_d = we_q ? ST_IDLE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_hit || timeout) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req           = (state_q == ST_REQ);
    MAU_data_conflict = (state_q != ST_IDLE);
  end

  always_comb begin
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_data_d = ld_data_q;
    ld_we_d   = resp_hit;
    exc_d     = misal_hit || timeout;
    cause_d   = cause_q;
    if (accept) begin
      addr_d  = addr_toMAU;
      be_d    = be_new;
      wdata_d = wdata_new;
      f3_d    = funct3;
      rd_d    = rd_idx;
      we_d    = !riscv_LOAD;
    end
    if ((state_q == ST_REQ) && mem_gnt) cnt_d = '0;
    else if (state_q == ST_WAIT_RESP)   cnt_d = cnt_q + 1'b1;
    if (resp_hit) begin
      ld_rd_d   = rd_q;
      ld_data_d = ld_ext;
    end
    if (misal_hit)    cause_d = riscv_LOAD ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
    else if (timeout) cause_d = CAUSE_TIMEOUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      ld_we_q   <= 1'b0;
      ld_rd_q   <= '0;
      ld_data_q <= '0;
      exc_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      ld_we_q   <= ld_we_d;
      ld_rd_q   <= ld_rd_d;
      ld_data_q <= ld_data_d;
      exc_q     <= exc_d;
      cause_q   <= cause_d;
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign ld_we         = ld_we_q;
  assign ld_rd         = ld_rd_q;
  assign ld_data       = ld_data_q;
  assign mau_exc       = exc_q;
  assign mau_exc_cause = cause_q;

endmodule

// File: tb/tb_mau_lsu.sv
// Randomized bench for mau_lsu against a transaction-level reference model.
module tb_mau_lsu;

  localparam int TO   = 4;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            riscv_LOAD = 1'b0, riscv_STORE = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [31:0]     addr_toMAU = '0, data_toMAU = '0;
  logic [RD_W-1:0] rd_idx = '0;
  logic            mem_req, mem_we;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            ld_we;
  logic [RD_W-1:0] ld_rd;
  logic [31:0]     ld_data;
  logic            MAU_data_conflict, mau_exc;
  logic [1:0]      mau_exc_cause;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] last_cause = 2'b00;

  always #5 clk = ~clk;

  mau_lsu #(.RESP_TIMEOUT(TO), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset),
    .riscv_LOAD(riscv_LOAD), .riscv_STORE(riscv_STORE),
    .funct3(funct3), .addr_toMAU(addr_toMAU), .data_toMAU(data_toMAU), .rd_idx(rd_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_we(ld_we), .ld_rd(ld_rd), .ld_data(ld_data),
    .MAU_data_conflict(MAU_data_conflict), .mau_exc(mau_exc), .mau_exc_cause(mau_exc_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, lane masks and load extension.
  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * off);
    case (f3)
      3'd0:    return int'(byte'(v[7:0]));
      3'd4:    return 32'(v[7:0]);
      3'd1:    return int'(shortint'(v[15:0]));
      3'd5:    return 32'(v[15:0]);
      default: return rdata;
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_ldwe"}, ld_we, 0);
    chk({tag, "_ldrd"}, ld_rd, 0);
    chk({tag, "_lddata"}, ld_data, 0);
    chk({tag, "_conflict"}, MAU_data_conflict, 0);
    chk({tag, "_exc"}, mau_exc, 0);
    chk({tag, "_cause"}, mau_exc_cause, 0);
  endtask

  task automatic idle_inputs();
    riscv_LOAD  = 1'b0;
    riscv_STORE = 1'b0;
  endtask

  // While busy, upstream noise on the request inputs must not be captured.
  task automatic busy_junk();
    riscv_LOAD  = 1'($urandom % 2);
    riscv_STORE = 1'($urandom % 2);
    funct3      = 3'($urandom % 8);
    addr_toMAU  = $urandom;
    data_toMAU  = $urandom;
    rd_idx      = RD_W'($urandom);
  endtask

  task automatic access(input bit ld, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [RD_W-1:0] rd, input int gd, input int rvd,
                        input logic [31:0] rdata);
    int          n;
    bit          mis, got;
    logic [7:0]  mask;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    logic [1:0]  ecause;
    n    = ref_size(f3);
    mis  = (addr % n) != 0;
    mask = 8'(((1 << n) - 1) << addr[1:0]);
    ebe  = mask[3:0];
    ewd  = (n == 1) ? 32'(data[7:0]) * 32'h01010101 :
           (n == 2) ? 32'(data[15:0]) * 32'h00010001 : data;
    eld  = ref_load(f3, addr[1:0], rdata);

    @(negedge clk);
    riscv_LOAD  = ld;
    riscv_STORE = !ld || both;
    funct3      = f3;
    addr_toMAU  = addr;
    data_toMAU  = data;
    rd_idx      = rd;
    chk("idle_conflict", MAU_data_conflict, 0);
    @(negedge clk);

    if (mis) begin
      idle_inputs();
      ecause = ld ? 2'b01 : 2'b10;
      chk("mis_req", mem_req, 0);
      chk("mis_exc", mau_exc, 1);
      chk("mis_cause", mau_exc_cause, ecause);
      chk("mis_conflict", MAU_data_conflict, 0);
      last_cause = ecause;
      @(negedge clk);
      chk("mis_exc_clr", mau_exc, 0);
      chk("mis_req2", mem_req, 0);
      return;
    end

    for (int i = 0; i <= gd; i++) begin
      busy_junk();
      mem_gnt    = (i == gd);
      mem_rvalid = 1'($urandom % 2);
      chk("req", mem_req, 1);
      chk("req_conflict", MAU_data_conflict, 1);
      chk("req_addr", mem_addr, {addr[31:2], 2'b00});
      chk("req_we", mem_we, !ld);
      if (!ld) begin
        chk("req_be", mem_be, ebe);
        chk("req_wdata", mem_wdata, ewd);
      end
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    if (!ld) begin
      idle_inputs();
      chk("st_done_req", mem_req, 0);
      chk("st_done_conflict", MAU_data_conflict, 0);
      chk("st_done_ldwe", ld_we, 0);
      chk("st_cause_hold", mau_exc_cause, last_cause);
      return;
    end

    got = 0;
    for (int j = 0; j < TO && !got; j++) begin
      busy_junk();
      mem_rvalid = (j == rvd);
      mem_rdata  = (j == rvd) ? rdata : $urandom;
      chk("wait_req", mem_req, 0);
      chk("wait_conflict", MAU_data_conflict, 1);
      chk("wait_ldwe", ld_we, 0);
      chk("wait_exc", mau_exc, 0);
      @(negedge clk);
      got = (j == rvd);
    end
    idle_inputs();
    mem_rvalid = 1'b0;

    if (got) begin
      chk("ld_we", ld_we, 1);
      chk("ld_data", ld_data, eld);
      chk("ld_rd", ld_rd, rd);
      chk("ld_conflict", MAU_data_conflict, 0);
      chk("ld_exc", mau_exc, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("ld_we_pulse", ld_we, 0);
      chk("ld_data_hold", ld_data, eld);
    end else begin
      chk("to_exc", mau_exc, 1);
      chk("to_cause", mau_exc_cause, 2'b11);
      chk("to_ldwe", ld_we, 0);
      chk("to_conflict", MAU_data_conflict, 0);
      last_cause = 2'b11;
      @(negedge clk);
      chk("to_exc_clr", mau_exc, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("to_stray_ldwe", ld_we, 0);
      chk("to_stray_req", mem_req, 0);
    end
    chk("cause_hold", mau_exc_cause, last_cause);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    logic [2:0] f3;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    access(0, 0, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 0, 0);
    access(0, 0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 3, 0, 0);
    access(1, 0, 3'b000, 32'h0000_0302, 0, 7, 0, 0, 32'h12F0_3456);
    access(1, 0, 3'b100, 32'h0000_0302, 0, 7, 1, 2, 32'h12F0_3456);
    access(1, 0, 3'b001, 32'h0000_0401, 0, 4, 0, 0, 0);
    access(0, 0, 3'b010, 32'h0000_0402, 32'h1234_5678, 0, 0, 0, 0);
    access(1, 0, 3'b010, 32'h0000_0600, 0, 9, 0, 99, 32'hCAFE_F00D);
    access(1, 1, 3'b101, 32'h0000_0702, 32'h5555_5555, 12, 2, 1, 32'h8001_7FFF);
    access(1, 0, 3'b010, 32'h0000_0804, 0, 0, 0, 0, 32'hA5A5_0F0F);

    // Reset while waiting for the response aborts the load silently.
    @(negedge clk);
    riscv_LOAD = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h0000_0500; rd_idx = 3;
    @(negedge clk);
    idle_inputs();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_pre_conflict", MAU_data_conflict, 1);
    #2 reset = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_post_ldwe", ld_we, 0);
    chk("rst_post_exc", mau_exc, 0);
    chk("rst_post_conflict", MAU_data_conflict, 0);
    last_cause = 2'b00;
    access(1, 0, 3'b010, 32'h0000_0500, 0, 3, 0, 0, 32'h7654_3210);

    for (int k = 0; k < 80; k++) begin
      op = $urandom % 3;
      if (op == 0) f3 = 3'($urandom % 3);
      else         f3 = 3'($urandom % 8);
      access(op != 0, op == 2, f3, $urandom, $urandom, RD_W'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 6), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
